seq_mult4: RTL and testbench
============================

// Module: seq_mult4
//
// PURPOSE
//   Sequential 4x4 unsigned shift-and-add multiplier. Produces an 8-bit product in 4 iterations.
//   Sits directly upstream of the existing adder4 (4-bit CLA: a[3:0]+b[3:0] -> sum[4:0]).
//   Each cycle it feeds adder4 the running partial product and the multiplicand, then consumes sum[4:0].
//   Provides a start/busy/done handshake to the surrounding lab datapath.
//
// PARAMETERS
//   N       4   operand width; fixed at 4 by adder4, not overridable
//   CNT_W   2   iteration counter width (log2 N)
//
// PORTS
//   clk      in   1   single clock, rising edge
//   rst      in   1   synchronous, active-high reset
//   start    in   1   request; sampled only in IDLE or DONE
//   a        in   4   multiplicand, captured on the accepting edge
//   b        in   4   multiplier, captured on the accepting edge
//   busy     out  1   high while in RUN
//   done     out  1   one-cycle pulse; product valid
//   product  out  8   a*b, registered, held until the next result
//
// BEHAVIOUR
//   Reset: on rst at a clk edge, state=IDLE, busy=0, done=0, product=8'h00, internal regs=0.
//     Reset overrides everything, including mid-RUN.
//   States: IDLE -> RUN -> DONE -> IDLE. busy=(state==RUN) and done=(state==DONE); both are Moore outputs.
//   IDLE/DONE with start=1: mcand<=a, lo<=b, hi<=0, cnt<=0, go to RUN.
//     This applies in DONE too, so back-to-back operations are allowed with no IDLE gap.
//   DONE with start=0: go to IDLE. IDLE with start=0: stay.
//   RUN, each edge, one iteration:
//     - add = lo[0] ? adder4(hi, mcand) : {1'b0, hi}   (5 bits)
//     - {hi, lo} <= {add[4:0], lo[3:1]}                 (9-bit right shift; add[0] enters lo[3])
//     - cnt <= cnt+1; after the iteration at cnt==3, go to DONE and product <= new {hi, lo}
//   Latency: start sampled at edge E0. RUN occupies the cycles after E0..E3. done=1 in the cycle after E4.
//     So done is high exactly 5 cycles after the cycle in which start was sampled.
//   start during RUN: ignored, with no effect on operands or count. a/b changing during RUN: no effect.
//   product changes only on the edge entering DONE; stable at all other times. No overflow: 15*15=225 fits in 8 bits.
//   Width rules: all arithmetic unsigned. The carry out of adder4 (sum[4]) is kept as the 5th shift bit, never dropped.
//
// STRUCTURE
//   Package seq_mult4_pkg: state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//     Also N=4, CNT_W=2, CNT_LAST=2'd3.
//   One sub-module: adder4 instance u_add (a=hi, b=mcand, sum=add_sum).
//     The lo[0] mux sits outside the adder.
//   Single always block for state/datapath regs; continuous assigns for busy, done and the add mux.
//   Unused state 2'd3 returns to IDLE.
//
// TESTING
//   1. rst=1 two cycles, then release -> busy=0, done=0, product=8'h00, state IDLE.
//   2. start, a=0, b=0 -> done 5 cycles later, product=8'h00; busy high exactly 4 cycles.
//   3. a=15, b=15 -> product=8'hE1 (225); a=13, b=11 -> product=8'h8F (143); a=1, b=9 -> 8'h09.
//   4. start a=3, b=5; pulse start with a=7, b=7 during RUN -> product=8'h0F, done still at +5 cycles.
//   5. start a=9, b=9, assert rst in 2nd RUN cycle -> next cycle IDLE, busy=0, done=0, product=8'h00.
//      Then start a=2, b=6 -> product=8'h0C.
//   6. Back-to-back: start held high, a=6, b=7 then a=10, b=12 on the DONE cycle.
//      -> product=8'h2A, done pulse, busy the next cycle, then product=8'h78.
//   Compare every run against an a*b reference model, then sweep all 256 operand pairs.

Source files
------------

// File: rtl/seq_mult4_pkg.sv
// Shared constants and state encoding for the sequential 4x4 multiplier.
package seq_mult4_pkg;

   // Operand width is fixed by the downstream adder4 and must not be changed.
   localparam int N     = 4;
   localparam int CNT_W = 2;

   // Value of the iteration counter during the final RUN iteration.
   localparam logic [CNT_W-1:0] CNT_LAST = 2'd3;

   // Encoding 2'd3 is unused and falls back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit carry-lookahead adder: sum[4:0] = a + b. sum[4] is the carry out.
module adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [4:0] sum
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // All carries come straight from generate/propagate terms, with no ripple chain.
   assign w_c[0] = 1'b0;
   assign w_c[1] = w_g[0];
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign sum = {w_c[4], w_p ^ w_c[3:0]};

endmodule

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// Each RUN cycle adds the multiplicand into the high half (when the current
// multiplier bit is 1). It then shifts {carry, hi, lo} right by one, so after
// four iterations {hi, lo} holds the 8-bit product.
module seq_mult4
   import seq_mult4_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   state_t           r_state;
   logic [N-1:0]     r_mcand;
   logic [N-1:0]     r_hi;
   logic [N-1:0]     r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [2*N-1:0]   r_product;

   state_t           w_state_nxt;
   logic             w_load;
   logic [N:0]       w_add_sum;
   logic [N:0]       w_add;

   // Running partial product plus multiplicand; the carry stays as bit 4.
   adder4 u_add (
      .a   (r_hi),
      .b   (r_mcand),
      .sum (w_add_sum)
   );

   // Add only when the multiplier bit shifting out is set.
   assign w_add = r_lo[0] ? w_add_sum : {1'b0, r_hi};

   // Next-state logic and the operand-load strobe.
   always_comb begin
      // NOTE: every output gets a default first so no path can leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
            end
         end
         S_RUN: begin
            if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            // A start request in DONE begins the next operation with no IDLE gap.
            if (start) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register, operand capture, iterative shift-add and result register.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it acts only at a clock edge and overrides a RUN in progress.
      if (rst) begin
         r_state   <= S_IDLE;
         r_mcand   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         // NOTE: non-blocking assignments let every register see the values from before this edge.
         r_state <= w_state_nxt;
         if (w_load) begin
            r_mcand <= a;
            r_lo    <= b;
            r_hi    <= '0;
            r_cnt   <= '0;
         end else if (r_state == S_RUN) begin
            {r_hi, r_lo} <= {w_add, r_lo[N-1:1]};
            r_cnt        <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) r_product <= {w_add, r_lo[N-1:1]};
         end
      end
   end

   assign busy    = (r_state == S_RUN);
   assign done    = (r_state == S_DONE);
   assign product = r_product;

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4: directed table, handshake corner cases,
// randomized operands with noise during RUN, and a full 256-pair sweep.
module tb_seq_mult4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] m_hold;      // product value the model expects to be held

   localparam int LATENCY = 5;
   localparam int TIMEOUT = 20;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   seq_mult4 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Reference model: plain unsigned multiplication.
   function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
      return 8'(x) * 8'(y);
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Called at the first negedge after the accepting edge; returns how many
   // samples it took to see done (1 = first RUN cycle).
   task automatic wait_done(input string tag, input bit noise, output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         check({tag, "_busy"}, 8'(busy), 8'd1);
         check({tag, "_hold"}, product, m_hold);
         if (noise) begin
            start = 1'($urandom);
            a     = 4'($urandom);
            b     = 4'($urandom);
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                         input logic [7:0] expv, input bit noise, input string tag);
      int lat;
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(negedge clk);
      start = 1'b0;
      wait_done(tag, noise, lat);
      start = 1'b0;
      check({tag, "_lat"}, 8'(lat), 8'(LATENCY));
      check({tag, "_done"}, 8'(done), 8'd1);
      check({tag, "_busy0"}, 8'(busy), 8'd0);
      check({tag, "_prod"}, product, expv);
      m_hold = expv;
      @(negedge clk);
      check({tag, "_pulse"}, 8'(done), 8'd0);
      check({tag, "_idle"}, 8'(busy), 8'd0);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      logic [3:0] ra;
      logic [3:0] rb;

      tbl[0] = '{4'd0,  4'd0,  8'h00};
      tbl[1] = '{4'd15, 4'd15, 8'hE1};
      tbl[2] = '{4'd13, 4'd11, 8'h8F};
      tbl[3] = '{4'd1,  4'd9,  8'h09};
      tbl[4] = '{4'd8,  4'd1,  8'h08};
      tbl[5] = '{4'd12, 4'd10, 8'h78};

      // Reset state.
      rst   = 1'b1;
      start = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      m_hold = 8'h00;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_done", 8'(done), 8'd0);
      check("rst_prod", product, 8'h00);
      @(negedge clk);
      check("idle_busy", 8'(busy), 8'd0);
      check("idle_done", 8'(done), 8'd0);

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
      end

      // start pulsed with new operands during RUN is ignored.
      @(negedge clk);
      start = 1'b1; a = 4'd3; b = 4'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 4'd7; b = 4'd7;
      @(negedge clk);
      start = 1'b0; a = 4'd0; b = 4'd0;
      lat = 3;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      check("ign_lat", 8'(lat), 8'(LATENCY));
      check("ign_prod", product, 8'h0F);
      m_hold = 8'h0F;
      @(negedge clk);
      check("ign_pulse", 8'(done), 8'd0);

      // Reset in the second RUN cycle aborts the operation.
      @(negedge clk);
      start = 1'b1; a = 4'd9; b = 4'd9;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 8'(busy), 8'd0);
      check("abort_done", 8'(done), 8'd0);
      check("abort_prod", product, 8'h00);
      m_hold = 8'h00;
      @(negedge clk);
      check("abort_stay", 8'(busy), 8'd0);
      run_op(4'd2, 4'd6, 8'h0C, 1'b0, "post_rst");

      // Back-to-back with start held high through DONE.
      @(negedge clk);
      start = 1'b1; a = 4'd6; b = 4'd7;
      @(negedge clk);
      wait_done("b2b1", 1'b0, lat);
      check("b2b1_lat", 8'(lat), 8'(LATENCY));
      check("b2b1_done", 8'(done), 8'd1);
      check("b2b1_prod", product, 8'h2A);
      m_hold = 8'h2A;
      a = 4'd10; b = 4'd12;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 8'(busy), 8'd1);
      check("b2b_nodone", 8'(done), 8'd0);
      check("b2b_hold", product, 8'h2A);
      wait_done("b2b2", 1'b0, lat);
      check("b2b2_lat", 8'(lat), 8'(LATENCY));
      check("b2b2_prod", product, 8'h78);
      m_hold = 8'h78;
      @(negedge clk);
      check("b2b2_pulse", 8'(done), 8'd0);

      // Random operands, with random start/a/b noise while in RUN.
      for (int i = 0; i < 40; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         run_op(ra, rb, ref_mul(ra, rb), 1'b1, $sformatf("rnd%0d", i));
      end

      // Exhaustive operand sweep.
      for (int i = 0; i < 256; i++) begin
         ra = 4'(i >> 4);
         rb = 4'(i);
         run_op(ra, rb, ref_mul(ra, rb), 1'b0, $sformatf("sw%0d_%0d", ra, rb));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
